// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: buffers the ioctl ROM download in a small FIFO and routes
// each byte by address. Bytes below SDRAM_BASE go to the byte-wide BRAM write
// port. Bytes at or above SDRAM_BASE are packed into 16-bit SDRAM words over a
// req/ack handshake. rom_ready rises once every byte has been committed.
// Optional feature macro: ROM_CHECKSUM_EN adds a 16-bit checksum output.
module rom_load_sequencer #(
  parameter int unsigned        FIFO_AW    = 2,
  parameter int unsigned        ADDR_W     = 25,
  parameter logic [ADDR_W-1:0]  SDRAM_BASE = ADDR_W'(32'h0009_0000)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              bram_wr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_data,
  output logic              sdr_req,
  input  logic              sdr_ack,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [15:0]       sdr_data,
  output logic [1:0]        sdr_be,
  output logic              rom_ready,
`ifdef ROM_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic              overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_clear;

  logic              r_dl_q;
  logic              w_dl_rise;

  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [7:0]        r_fifo_data [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_ok;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic [7:0]        w_head_data;
  logic              w_head_sdr;
  logic              w_pair;
  logic              w_active;

  logic              r_wait;
  logic              r_overflow;
  logic              r_rom_ready;

  logic              r_bram_wr;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [7:0]        r_bram_data;
  logic              w_bram_wr_d;

  logic              r_sdr_req;
  logic [ADDR_W-1:0] r_sdr_addr;
  logic [15:0]       r_sdr_data;
  logic [1:0]        r_sdr_be;
  logic              w_sdr_issue;
  logic [ADDR_W-1:0] w_sdr_addr_d;
  logic [15:0]       w_sdr_data_d;
  logic [1:0]        w_sdr_be_d;

  logic              r_hold_valid;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [7:0]        r_hold_data;
  logic              w_hold_load;
  logic              w_hold_clr;

  assign w_dl_rise   = ioctl_download & ~r_dl_q;
  assign w_wr_ok     = ioctl_wr & ioctl_download;
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = w_wr_ok & ~w_full;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_sdr  = (w_head_addr >= SDRAM_BASE);
  // Head byte is the odd partner of the held even byte.
  assign w_pair      = r_hold_valid & w_head_sdr & w_head_addr[0] &
                       (w_head_addr[ADDR_W-1:1] == r_hold_addr[ADDR_W-1:1]);
  assign w_active    = (r_state == S_LOAD) || (r_state == S_DRAIN);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; w_clear marks a fresh download start.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dl_rise) begin
          w_state_nxt = S_LOAD;
          w_clear     = 1'b1;
        end
      end
      S_LOAD: begin
        if (!ioctl_download) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_dl_rise) begin
          w_state_nxt = S_LOAD;
        end else if (w_empty && !r_sdr_req && !r_hold_valid && !r_bram_wr) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_dl_rise) begin
          w_state_nxt = S_LOAD;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Dispatcher: one decision per cycle, stalled while an SDRAM request is open.
  always_comb begin
    w_pop        = 1'b0;
    w_bram_wr_d  = 1'b0;
    w_sdr_issue  = 1'b0;
    w_sdr_addr_d = '0;
    w_sdr_data_d = '0;
    w_sdr_be_d   = '0;
    w_hold_load  = 1'b0;
    w_hold_clr   = 1'b0;
    if (w_active && !r_sdr_req) begin
      if (!w_empty) begin
        if (r_hold_valid && !w_pair) begin
          // Held byte cannot pair with the head: write it alone first.
          w_sdr_issue  = 1'b1;
          w_sdr_addr_d = r_hold_addr;
          w_sdr_data_d = {8'h00, r_hold_data};
          w_sdr_be_d   = 2'b01;
          w_hold_clr   = 1'b1;
        end else if (!w_head_sdr) begin
          w_pop       = 1'b1;
          w_bram_wr_d = 1'b1;
        end else if (!w_head_addr[0]) begin
          w_pop       = 1'b1;
          w_hold_load = 1'b1;
        end else if (w_pair) begin
          w_pop        = 1'b1;
          w_sdr_issue  = 1'b1;
          w_sdr_addr_d = r_hold_addr;
          w_sdr_data_d = {w_head_data, r_hold_data};
          w_sdr_be_d   = 2'b11;
          w_hold_clr   = 1'b1;
        end else begin
          w_pop        = 1'b1;
          w_sdr_issue  = 1'b1;
          w_sdr_addr_d = {w_head_addr[ADDR_W-1:1], 1'b0};
          w_sdr_data_d = {w_head_data, 8'h00};
          w_sdr_be_d   = 2'b10;
        end
      end else if (r_state == S_DRAIN && r_hold_valid) begin
        // Download over and nothing left to pair with: flush the held byte.
        w_sdr_issue  = 1'b1;
        w_sdr_addr_d = r_hold_addr;
        w_sdr_data_d = {8'h00, r_hold_data};
        w_sdr_be_d   = 2'b01;
        w_hold_clr   = 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= ioctl_addr;
      r_fifo_data[r_wr_ptr] <= ioctl_dout;
    end
  end

  // FIFO pointers, loader throttle, overflow flag and completion flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_q      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wait      <= 1'b0;
      r_overflow  <= 1'b0;
      r_rom_ready <= 1'b0;
    end else begin
      r_dl_q <= ioctl_download;
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_count <= w_count_nxt;
      r_wait  <= (w_count_nxt >= CNT_W'(DEPTH - 1));
      if (w_clear)                r_overflow <= 1'b0;
      else if (w_wr_ok && w_full) r_overflow <= 1'b1;
      r_rom_ready <= (w_state_nxt == S_DONE);
    end
  end

  // BRAM write port: strobe one cycle after the pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bram_wr   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_data <= '0;
    end else begin
      r_bram_wr <= w_bram_wr_d;
      if (w_bram_wr_d) begin
        r_bram_addr <= w_head_addr;
        r_bram_data <= w_head_data;
      end
    end
  end

  // SDRAM request: held until ack, then dropped for at least one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sdr_req  <= 1'b0;
      r_sdr_addr <= '0;
      r_sdr_data <= '0;
      r_sdr_be   <= '0;
    end else if (w_sdr_issue) begin
      r_sdr_req  <= 1'b1;
      r_sdr_addr <= w_sdr_addr_d;
      r_sdr_data <= w_sdr_data_d;
      r_sdr_be   <= w_sdr_be_d;
    end else if (r_sdr_req && sdr_ack) begin
      r_sdr_req  <= 1'b0;
    end
  end

  // Even-byte holding register for SDRAM word packing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_valid <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
    end else if (w_hold_load) begin
      r_hold_valid <= 1'b1;
      r_hold_addr  <= w_head_addr;
      r_hold_data  <= w_head_data;
    end else if (w_hold_clr) begin
      r_hold_valid <= 1'b0;
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] r_checksum;
  logic [15:0] w_sum_add;

  // Bytes committed this cycle: BRAM strobe plus enabled SDRAM bytes at ack.
  always_comb begin
    w_sum_add = '0;
    if (r_bram_wr) w_sum_add = {8'h00, r_bram_data};
    if (r_sdr_req && sdr_ack) begin
      if (r_sdr_be[0]) w_sum_add = w_sum_add + {8'h00, r_sdr_data[7:0]};
      if (r_sdr_be[1]) w_sum_add = w_sum_add + {8'h00, r_sdr_data[15:8]};
    end
  end

  // Wrapping byte sum, restarted with each new download.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_checksum <= '0;
    else if (w_clear) r_checksum <= '0;
    else              r_checksum <= r_checksum + w_sum_add;
  end

  assign checksum = r_checksum;
`endif

  assign ioctl_wait = r_wait;
  assign bram_wr    = r_bram_wr;
  assign bram_addr  = r_bram_addr;
  assign bram_data  = r_bram_data;
  assign sdr_req    = r_sdr_req;
  assign sdr_addr   = r_sdr_addr;
  assign sdr_data   = r_sdr_data;
  assign sdr_be     = r_sdr_be;
  assign rom_ready  = r_rom_ready;
  assign overflow   = r_overflow;

endmodule
